// File: rtl/mem_arbiter.sv
// Shares one PSRAM controller between the CPU (read/write) and the VIC-II (read-only).
// A VIC grant streak is capped while the CPU waits, and stalled transactions are aborted by a watchdog.
module mem_arbiter #(
    parameter int MAX_VIC_STREAK = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_write,
    input  logic [3:0]  cpu_bank,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        vic_req,
    input  logic [3:0]  vic_bank,
    input  logic [15:0] vic_addr,
    output logic        vic_ack,
    output logic [7:0]  vic_rdata,
    output logic        mem_ce,
    output logic        mem_write,
    output logic [3:0]  mem_bank,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_busy,
    output logic        timeout_err
);
    localparam int CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int STREAK_W = $clog2(MAX_VIC_STREAK + 1);
    localparam logic [CNT_W-1:0]    TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_VIC_STREAK);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        COMPLETE  = 3'd4
    } state_t;

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    tmo_cnt_r, tmo_cnt_s;
    logic [STREAK_W-1:0] streak_r, streak_s;
    logic                grant_vic_r, grant_vic_s;
    logic                cpu_ack_s, vic_ack_s, mem_ce_s, mem_write_s, timeout_err_s;
    logic [7:0]          cpu_rdata_s, vic_rdata_s, mem_wdata_s;
    logic [3:0]          mem_bank_s;
    logic [15:0]         mem_addr_s;
    logic                finish_s, abort_s;

    // Next-state, arbitration and next-output computation
    always_comb begin
        state_s       = state_r;
        tmo_cnt_s     = tmo_cnt_r;
        streak_s      = streak_r;
        grant_vic_s   = grant_vic_r;
        mem_ce_s      = 1'b0;
        mem_write_s   = mem_write;
        mem_bank_s    = mem_bank;
        mem_addr_s    = mem_addr;
        mem_wdata_s   = mem_wdata;
        cpu_ack_s     = 1'b0;
        vic_ack_s     = 1'b0;
        cpu_rdata_s   = cpu_rdata;
        vic_rdata_s   = vic_rdata;
        timeout_err_s = timeout_err;
        finish_s      = 1'b0;
        abort_s       = 1'b0;

        case (state_r)
            IDLE: begin
                if (!mem_busy && (cpu_req || vic_req)) begin
                    state_s  = ISSUE;
                    mem_ce_s = 1'b1;
                    // VIC has priority until its streak would starve a waiting CPU
                    if (vic_req && (!cpu_req || (streak_r != STREAK_MAX))) begin
                        grant_vic_s = 1'b1;
                        mem_write_s = 1'b0;
                        mem_bank_s  = vic_bank;
                        mem_addr_s  = vic_addr;
                        mem_wdata_s = 8'h00;
                        if (cpu_req) begin
                            streak_s = streak_r + STREAK_W'(1);
                        end else begin
                            streak_s = '0;
                        end
                    end else begin
                        grant_vic_s = 1'b0;
                        mem_write_s = cpu_write;
                        mem_bank_s  = cpu_bank;
                        mem_addr_s  = cpu_addr;
                        mem_wdata_s = cpu_wdata;
                        streak_s    = '0;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                state_s   = WAIT_BUSY;
                tmo_cnt_s = '0;
            end
            WAIT_BUSY: begin
                if (tmo_cnt_r == TMO_LAST) begin
                    abort_s = 1'b1;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + CNT_W'(1);
                    if (mem_busy) begin
                        state_s = WAIT_DONE;
                    end else begin
                        state_s = WAIT_BUSY;
                    end
                end
            end
            WAIT_DONE: begin
                if (tmo_cnt_r == TMO_LAST) begin
                    abort_s = 1'b1;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + CNT_W'(1);
                    if (!mem_busy) begin
                        finish_s = 1'b1;
                    end else begin
                        state_s = WAIT_DONE;
                    end
                end
            end
            COMPLETE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // Ack and read data are registered on entry to COMPLETE so they line up with it
        if (abort_s || finish_s) begin
            state_s = COMPLETE;
            if (grant_vic_r) begin
                vic_ack_s = 1'b1;
            end else begin
                cpu_ack_s = 1'b1;
            end
            if (abort_s) begin
                timeout_err_s = 1'b1;
                if (grant_vic_r) begin
                    vic_rdata_s = 8'hFF;
                end else begin
                    cpu_rdata_s = 8'hFF;
                end
            end else if (!mem_write) begin
                if (grant_vic_r) begin
                    vic_rdata_s = mem_rdata;
                end else begin
                    cpu_rdata_s = mem_rdata;
                end
            end else begin
                cpu_rdata_s = cpu_rdata;
                vic_rdata_s = vic_rdata;
            end
        end else begin
            cpu_ack_s = 1'b0;
            vic_ack_s = 1'b0;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            tmo_cnt_r   <= '0;
            streak_r    <= '0;
            grant_vic_r <= 1'b0;
            cpu_ack     <= 1'b0;
            cpu_rdata   <= 8'h00;
            vic_ack     <= 1'b0;
            vic_rdata   <= 8'h00;
            mem_ce      <= 1'b0;
            mem_write   <= 1'b0;
            mem_bank    <= 4'h0;
            mem_addr    <= 16'h0000;
            mem_wdata   <= 8'h00;
            timeout_err <= 1'b0;
        end else begin
            state_r     <= state_s;
            tmo_cnt_r   <= tmo_cnt_s;
            streak_r    <= streak_s;
            grant_vic_r <= grant_vic_s;
            cpu_ack     <= cpu_ack_s;
            cpu_rdata   <= cpu_rdata_s;
            vic_ack     <= vic_ack_s;
            vic_rdata   <= vic_rdata_s;
            mem_ce      <= mem_ce_s;
            mem_write   <= mem_write_s;
            mem_bank    <= mem_bank_s;
            mem_addr    <= mem_addr_s;
            mem_wdata   <= mem_wdata_s;
            timeout_err <= timeout_err_s;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a PSRAM controller model plus a transaction-level reference
// model of arbitration, latency, read data and the timeout watchdog.
module tb_mem_arbiter;
    localparam int MAX_STREAK = 4;
    localparam int TMO        = 16;

    logic        clk, reset;
    logic        cpu_req, cpu_write, cpu_ack;
    logic [3:0]  cpu_bank;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        vic_req, vic_ack;
    logic [3:0]  vic_bank;
    logic [15:0] vic_addr;
    logic [7:0]  vic_rdata;
    logic        mem_ce, mem_write, mem_busy, timeout_err;
    logic [3:0]  mem_bank;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    mem_arbiter #(.MAX_VIC_STREAK(MAX_STREAK), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_bank(cpu_bank), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .vic_req(vic_req), .vic_bank(vic_bank), .vic_addr(vic_addr),
        .vic_ack(vic_ack), .vic_rdata(vic_rdata),
        .mem_ce(mem_ce), .mem_write(mem_write), .mem_bank(mem_bank), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_busy(mem_busy),
        .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total_cnt = 0;
    int bad_cnt   = 0;

    // Reference model state
    int          cyc = 0;
    int          streak = 0;
    logic [7:0]  cpu_rd_m = 8'h00, vic_rd_m = 8'h00;
    logic        terr_m = 1'b0;
    bit          act = 1'b0, t_vic, t_write, t_hang;
    logic [28:0] t_fields;
    logic [7:0]  t_rdata;
    int          exp_ack, bs, be;
    int          last_grant_cyc = 0, last_ack_cyc = 0;
    logic [7:0]  mem_m [logic [19:0]];
    bit          grant_log [$];
    bit          cpu_pend = 1'b0, vic_pend = 1'b0, hold_mode = 1'b0, hang_mode = 1'b0, ext_busy = 1'b0;
    int          fixed_b = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] mem_get(input logic [19:0] key);
        if (mem_m.exists(key)) return mem_m[key];
        return key[7:0] ^ key[15:8] ^ {4'h0, key[19:16]};
    endfunction

    task automatic drive_busy();
        mem_busy = ext_busy || (act && cyc >= bs && cyc <= be);
    endtask

    task automatic cpu_issue(input logic w, input logic [3:0] b, input logic [15:0] a, input logic [7:0] d);
        cpu_write = w; cpu_bank = b; cpu_addr = a; cpu_wdata = d;
        cpu_req = 1'b1; cpu_pend = 1'b1;
    endtask

    task automatic vic_issue(input logic [3:0] b, input logic [15:0] a);
        vic_bank = b; vic_addr = a;
        vic_req = 1'b1; vic_pend = 1'b1;
    endtask

    task automatic cpu_rand();
        cpu_issue(1'($urandom), 4'($urandom_range(0, 1)), 16'($urandom_range(0, 7)), 8'($urandom));
    endtask

    task automatic vic_rand();
        vic_issue(4'($urandom_range(0, 1)), 16'($urandom_range(0, 7)));
    endtask

    // One clock: observe at negedge, score against the model, then react as requesters/controller
    task automatic tick();
        logic        exp_cack, exp_vack, done, vic_w;
        logic [28:0] exp_f;
        int          b;
        @(negedge clk);
        cyc++;
        exp_cack = 1'b0; exp_vack = 1'b0; done = 1'b0;
        if (reset) begin
            check_val("reset_outs", 64'({cpu_ack, cpu_rdata, vic_ack, vic_rdata, mem_ce, mem_write,
                      mem_bank, mem_addr, mem_wdata, timeout_err}), 64'd0);
            streak = 0; cpu_rd_m = 8'h00; vic_rd_m = 8'h00; terr_m = 1'b0; act = 1'b0;
        end else begin
            if (act && cyc == exp_ack) begin
                done = 1'b1;
                if (t_hang) begin
                    terr_m = 1'b1;
                    if (t_vic) vic_rd_m = 8'hFF; else cpu_rd_m = 8'hFF;
                end else if (!t_write) begin
                    if (t_vic) vic_rd_m = t_rdata; else cpu_rd_m = t_rdata;
                end
                if (t_vic) exp_vack = 1'b1; else exp_cack = 1'b1;
            end
            check_val("cpu_ack", 64'(cpu_ack), 64'(exp_cack));
            check_val("vic_ack", 64'(vic_ack), 64'(exp_vack));
            check_val("cpu_rdata", 64'(cpu_rdata), 64'(cpu_rd_m));
            check_val("vic_rdata", 64'(vic_rdata), 64'(vic_rd_m));
            check_val("timeout_err", 64'(timeout_err), 64'(terr_m));
            if (act) check_val("mem_hold", 64'({mem_write, mem_bank, mem_addr, mem_wdata}), 64'(t_fields));
            if (act) check_val("ce_overlap", 64'(mem_ce), 64'd0);
            else if (mem_busy) check_val("ce_while_busy", 64'(mem_ce), 64'd0);
            else if (!cpu_req && !vic_req) check_val("ce_no_req", 64'(mem_ce), 64'd0);
            else if (mem_ce) begin
                vic_w = vic_req && (!cpu_req || streak < MAX_STREAK);
                if (vic_w) streak = cpu_req ? ((streak < MAX_STREAK) ? streak + 1 : streak) : 0;
                else streak = 0;
                grant_log.push_back(vic_w);
                exp_f = vic_w ? {1'b0, vic_bank, vic_addr, 8'h00} : {cpu_write, cpu_bank, cpu_addr, cpu_wdata};
                check_val("grant_fields", 64'({mem_write, mem_bank, mem_addr, mem_wdata}), 64'(exp_f));
                t_fields = exp_f; t_vic = vic_w; t_write = exp_f[28]; t_hang = hang_mode;
                t_rdata = mem_get(exp_f[27:8]);
                if (t_write) mem_m[exp_f[27:8]] = exp_f[7:0];
                act = 1'b1;
                last_grant_cyc = cyc;
                bs = cyc + 1;
                if (hang_mode) begin
                    exp_ack = cyc + 1 + TMO;
                    be = cyc + 1000000;
                end else begin
                    b = (fixed_b > 0) ? fixed_b : $urandom_range(1, 6);
                    exp_ack = cyc + b + 2;
                    be = cyc + b;
                end
                mem_rdata = t_rdata;
            end
            if (done) act = 1'b0;
            if (cpu_ack || vic_ack) last_ack_cyc = cyc;
            if (cpu_ack && cpu_pend) begin
                if (hold_mode) cpu_rand(); else begin cpu_req = 1'b0; cpu_pend = 1'b0; end
            end
            if (vic_ack && vic_pend) begin
                if (hold_mode) vic_rand(); else begin vic_req = 1'b0; vic_pend = 1'b0; end
            end
        end
        drive_busy();
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((cpu_pend || vic_pend || act) && n < bound) begin
            tick();
            n++;
        end
        check_val("idle_reached", 64'({cpu_pend, vic_pend}), 64'd0);
        cpu_req = 1'b0; vic_req = 1'b0; cpu_pend = 1'b0; vic_pend = 1'b0;
    endtask

    task automatic do_reset();
        cpu_req = 1'b0; vic_req = 1'b0; cpu_pend = 1'b0; vic_pend = 1'b0;
        hold_mode = 1'b0; hang_mode = 1'b0; ext_busy = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int n, ce_seen;
        reset = 1'b1; cpu_req = 1'b0; cpu_write = 1'b0; cpu_bank = 4'h0; cpu_addr = 16'h0000;
        cpu_wdata = 8'h00; vic_req = 1'b0; vic_bank = 4'h0; vic_addr = 16'h0000;
        mem_busy = 1'b0; mem_rdata = 8'h00;
        mem_m[{4'h0, 16'h0400}] = 8'h5A;
        tick(); tick();
        reset = 1'b0;

        // CPU write, fixed busy length 5
        fixed_b = 5;
        cpu_issue(1'b1, 4'h3, 16'h1234, 8'hA5);
        wait_idle(50);
        check_val("t1_latency", 64'(last_ack_cyc - last_grant_cyc + 1), 64'd8);
        check_val("t1_rdata", 64'(cpu_rdata), 64'h00);

        // VIC read of preloaded location, then CPU readback of the earlier write
        vic_issue(4'h0, 16'h0400);
        wait_idle(50);
        check_val("t2_vic_rdata", 64'(vic_rdata), 64'h5A);
        cpu_issue(1'b0, 4'h3, 16'h1234, 8'h00);
        wait_idle(50);
        check_val("t2_readback", 64'(cpu_rdata), 64'hA5);

        // Both requesters held continuously: streak cap forces every fifth grant to the CPU
        fixed_b = 2;
        do_reset();
        grant_log.delete();
        hold_mode = 1'b1;
        cpu_rand(); vic_rand();
        n = 0;
        while (grant_log.size() < 10 && n < 400) begin tick(); n++; end
        hold_mode = 1'b0;
        wait_idle(100);
        check_val("t3_grants", 64'(grant_log.size() >= 10), 64'd1);
        for (int i = 0; i < 10 && i < grant_log.size(); i++)
            check_val($sformatf("t3_order%0d", i), 64'(grant_log[i]), 64'((i % 5) != 4));

        // Controller hangs: watchdog aborts, error flag is sticky across a good transaction
        hang_mode = 1'b1;
        vic_issue(4'h1, 16'h0010);
        wait_idle(60);
        hang_mode = 1'b0;
        check_val("t4_latency", 64'(last_ack_cyc - last_grant_cyc), 64'(TMO + 1));
        check_val("t4_rdata", 64'(vic_rdata), 64'hFF);
        cpu_issue(1'b0, 4'h0, 16'h0400, 8'h00);
        wait_idle(50);
        check_val("t4_terr_sticky", 64'(timeout_err), 64'd1);
        check_val("t4_good_read", 64'(cpu_rdata), 64'h5A);

        // Reset while waiting for busy to fall
        fixed_b = 6;
        cpu_issue(1'b0, 4'h3, 16'h1234, 8'h00);
        n = 0;
        while (!(act && cyc >= last_grant_cyc + 3) && n < 20) begin tick(); n++; end
        do_reset();
        check_val("t5_terr_clr", 64'(timeout_err), 64'd0);
        for (int i = 0; i < 8; i++) tick();
        check_val("t5_no_ack", 64'({cpu_ack, vic_ack}), 64'd0);
        cpu_issue(1'b0, 4'h3, 16'h1234, 8'h00);
        wait_idle(50);
        check_val("t5_read", 64'(cpu_rdata), 64'hA5);

        // Controller busy from elsewhere holds off the grant
        ext_busy = 1'b1; drive_busy();
        cpu_issue(1'b1, 4'h2, 16'h0042, 8'h3C);
        ce_seen = 0;
        for (int i = 0; i < 6; i++) begin tick(); if (mem_ce) ce_seen++; end
        check_val("t6_no_ce", 64'(ce_seen), 64'd0);
        ext_busy = 1'b0; drive_busy();
        wait_idle(50);
        check_val("t6_fields", 64'(t_fields), 64'({1'b1, 4'h2, 16'h0042, 8'h3C}));

        // Randomized traffic
        fixed_b = 0;
        for (int k = 0; k < 600; k++) begin
            tick();
            if (!act && !ext_busy && $urandom_range(0, 19) == 0) ext_busy = 1'b1;
            else if (ext_busy && $urandom_range(0, 2) == 0) ext_busy = 1'b0;
            drive_busy();
            if (!cpu_pend && $urandom_range(0, 3) == 0) cpu_rand();
            if (!vic_pend && $urandom_range(0, 3) == 0) vic_rand();
        end
        ext_busy = 1'b0; drive_busy();
        wait_idle(200);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
